// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the two buses of the instruction-memory loader:
//     - byte stream from the host link: byte_valid, byte_data (in), byte_ready (out)
//     - IMEM write port: mem_we, mem_addr, mem_wdata (out)
//   master : the loader side (consumes bytes, drives the IMEM write port)
//   slave  : the environment side (host byte source and IMEM)
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction memory. Receives a byte stream holding a 16-bit
//   little-endian word count followed by little-endian 32-bit instruction words, writes
//   the words to IMEM from byte address 0 upward, then fills every remaining word up to
//   DEPTH-1 with HALT_INSTR so a fetch past the end of the program reads HALT.
//   Ports:
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     start         1-cycle pulse, begins a load when not busy
//     abort         level, cancels a load in progress (back to IDLE)
//     bus           byte stream in + IMEM write port out (imem_loader_if.master)
//     busy          load in progress
//     done / error  load completed / word count exceeded DEPTH; held until next start
//     word_count    program words written so far (fill writes excluded)
//   All outputs come straight from registers. DEPTH must be at least 2.
module imem_loader #(
    parameter int          DEPTH      = 128,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0063
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    imem_loader_if.master        bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          word_count
);
    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [15:0]       DEPTH_LEN = 16'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, PAD, DONE, ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       len_reg, len_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [1:0]        bytecnt_reg, bytecnt_next;
    logic [31:0]       shift_reg, shift_next;
    logic [15:0]       count_reg, count_next;
    logic              byte_ready_reg, byte_ready_next;
    logic              mem_we_reg, mem_we_next;
    logic [31:0]       mem_addr_reg, mem_addr_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              error_reg, error_next;

    logic              xfer;
    logic [IDX_W-1:0]  idx_plus1;
    logic [15:0]       idx_plus1_len;
    logic [15:0]       len_full;

    // Byte address of a word index; upper address bits are structurally zero.
    function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] i);
        return {{(30 - IDX_W){1'b0}}, i, 2'b00};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            idx_reg        <= '0;
            bytecnt_reg    <= '0;
            shift_reg      <= '0;
            count_reg      <= '0;
            byte_ready_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            idx_reg        <= idx_next;
            bytecnt_reg    <= bytecnt_next;
            shift_reg      <= shift_next;
            count_reg      <= count_next;
            byte_ready_reg <= byte_ready_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
        end
    end

    // Next-state logic. The output registers are loaded with the values belonging to
    // state_next, so e.g. the write strobe is high during the whole WRITE/PAD cycle and
    // the write presented in that cycle always completes even if abort arrives.
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        idx_next       = idx_reg;
        bytecnt_next   = bytecnt_reg;
        shift_next     = shift_reg;
        count_next     = count_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;

        xfer          = bus.byte_valid && byte_ready_reg;
        idx_plus1     = idx_reg + IDX_ONE;
        idx_plus1_len = 16'(idx_reg) + 16'd1;
        len_full      = {bus.byte_data, len_reg[7:0]};

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start && !abort) begin
                    state_next = LEN_LO;
                    count_next = '0;
                end
            end
            LEN_LO: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    len_next[7:0] = bus.byte_data;
                    state_next    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    len_next     = len_full;
                    idx_next     = '0;
                    bytecnt_next = '0;
                    if (len_full > DEPTH_LEN) begin
                        state_next = ERR;
                    end else if (len_full == 16'd0) begin
                        state_next     = PAD;
                        mem_we_next    = 1'b1;
                        mem_addr_next  = word_addr('0);
                        mem_wdata_next = HALT_INSTR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    // Little-endian assembly: after four shifts the first byte is in [7:0].
                    shift_next   = {bus.byte_data, shift_reg[31:8]};
                    bytecnt_next = bytecnt_reg + 2'd1;
                    if (bytecnt_reg == 2'd3) begin
                        state_next     = WRITE;
                        mem_we_next    = 1'b1;
                        mem_addr_next  = word_addr(idx_reg);
                        mem_wdata_next = shift_next;
                    end
                end
            end
            WRITE: begin
                count_next = count_reg + 16'd1;
                if (abort) begin
                    state_next = IDLE;
                end else if (idx_plus1_len == len_reg) begin
                    if (len_reg < DEPTH_LEN) begin
                        state_next     = PAD;
                        idx_next       = idx_plus1;
                        mem_we_next    = 1'b1;
                        mem_addr_next  = word_addr(idx_plus1);
                        mem_wdata_next = HALT_INSTR;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    state_next = DATA;
                    idx_next   = idx_plus1;
                end
            end
            PAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (idx_reg == LAST_IDX) begin
                    // Index stays at DEPTH-1 rather than wrapping.
                    state_next = DONE;
                end else begin
                    idx_next       = idx_plus1;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = word_addr(idx_plus1);
                    mem_wdata_next = HALT_INSTR;
                end
            end
            default: state_next = IDLE;
        endcase

        byte_ready_next = (state_next == LEN_LO) || (state_next == LEN_HI) ||
                          (state_next == DATA);
        busy_next       = byte_ready_next || (state_next == WRITE) || (state_next == PAD);
        done_next       = (state_next == DONE);
        error_next      = (state_next == ERR);
    end

    assign bus.byte_ready = byte_ready_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign error          = error_reg;
    assign word_count     = count_reg;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader: loads programs over the byte stream, mirrors IMEM
//   writes into a local array and compares against hand-computed contents and status.
module tb_imem_loader;
    localparam int          DEPTH = 128;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] HALT  = 32'h0000_0063;
    localparam logic [31:0] FILL  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, error;
    logic [15:0] word_count;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH), .HALT_INSTR(HALT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus.master),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int          cmp_count = 0;
    int          err_count = 0;
    logic [31:0] mem [DEPTH];
    int          wr_count = 0;
    int          bad_addr = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] first_wdata = '0;

    // IMEM model: capture every write strobe mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (wr_count == 0) first_wdata = bus.mem_wdata;
            if (bus.mem_addr[1:0] != 2'b00 || bus.mem_addr >= 32'(DEPTH * 4))
                bad_addr++;
            else
                mem[bus.mem_addr[AW+1:2]] = bus.mem_wdata;
            last_addr = bus.mem_addr;
            wr_count++;
        end
    end

    task automatic clear_log();
        for (int i = 0; i < DEPTH; i++) mem[i] = FILL;
        wr_count = 0; bad_addr = 0; last_addr = '0; first_wdata = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; 'poke' raises start during the gap.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic poke);
        int t;
        @(negedge clk);
        for (int g = 0; g < gap; g++) begin
            bus.byte_valid = 1'b0; start = poke;
            @(negedge clk);
        end
        start = 1'b0;
        bus.byte_valid = 1'b1; bus.byte_data = b;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            cmp_count++; err_count++;
            $display("FAIL byte_ready_timeout: got byte_ready=%b want 1 within 200 cycles", bus.byte_ready);
        end
        @(posedge clk);
        #1 bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0, 1'b0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        $display("load: done=%b error=%b word_count=%0d writes=%0d cycles=%0d",
                 done, error, word_count, wr_count, t);
    endtask

    function automatic int count_bad_pad(input int from);
        int bad;
        bad = 0;
        for (int i = from; i < DEPTH; i++) if (mem[i] !== HALT) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        cmp_count++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin err_count++; $display("FAIL reset_status: got busy=%b done=%b error=%b want 0 0 0", busy, done, error); end
        cmp_count++; if (word_count !== 16'd0) begin err_count++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        cmp_count++; if (bus.byte_ready !== 1'b0 || bus.mem_we !== 1'b0) begin err_count++; $display("FAIL reset_bus: got ready=%b we=%b want 0 0", bus.byte_ready, bus.mem_we); end
        cmp_count++; if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin err_count++; $display("FAIL reset_mem: got addr=%h wdata=%h want 0 0", bus.mem_addr, bus.mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_len2();
        int bad;
        clear_log();
        pulse_start();
        cmp_count++; if (busy !== 1'b1) begin err_count++; $display("FAIL len2_busy: got %b want 1", busy); end
        send_byte(8'h02, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        send_byte(8'h78, 0, 1'b0); send_byte(8'h56, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0); send_byte(8'h12, 0, 1'b0);
        @(negedge clk);
        cmp_count++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h12345678) begin err_count++; $display("FAIL len2_latency: got we=%b addr=%h data=%h want 1 0 12345678", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        send_word(32'h9ABCDEF0);
        wait_done();
        cmp_count++; if (mem[0] !== 32'h12345678 || mem[1] !== 32'h9ABCDEF0) begin err_count++; $display("FAIL len2_data: got %h %h want 12345678 9abcdef0", mem[0], mem[1]); end
        bad = count_bad_pad(2);
        cmp_count++; if (bad !== 0) begin err_count++; $display("FAIL len2_pad: got %0d bad pad words want 0", bad); end
        cmp_count++; if (wr_count !== DEPTH || bad_addr !== 0 || last_addr !== 32'h1FC) begin err_count++; $display("FAIL len2_writes: got n=%0d bad=%0d last=%h want 128 0 1fc", wr_count, bad_addr, last_addr); end
        cmp_count++; if (done !== 1'b1 || busy !== 1'b0 || word_count !== 16'd2) begin err_count++; $display("FAIL len2_status: got done=%b busy=%b wc=%0d want 1 0 2", done, busy, word_count); end
    endtask

    task automatic test_len0();
        int bad;
        clear_log();
        pulse_start();
        cmp_count++; if (done !== 1'b0) begin err_count++; $display("FAIL len0_done_clear: got %b want 0", done); end
        send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        wait_done();
        bad = count_bad_pad(0);
        cmp_count++; if (bad !== 0 || wr_count !== DEPTH || first_wdata !== HALT) begin err_count++; $display("FAIL len0_pad: got bad=%0d n=%0d first=%h want 0 128 63", bad, wr_count, first_wdata); end
        cmp_count++; if (done !== 1'b1 || word_count !== 16'd0 || last_addr !== 32'h1FC) begin err_count++; $display("FAIL len0_status: got done=%b wc=%0d last=%h want 1 0 1fc", done, word_count, last_addr); end
    endtask

    task automatic test_len128();
        int bad;
        clear_log();
        pulse_start();
        send_byte(8'h80, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) send_word(32'h1000_0000 + 32'(i));
        wait_done();
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'h1000_0000 + 32'(i)) bad++;
        cmp_count++; if (bad !== 0 || mem[DEPTH-1] !== 32'h1000_007F) begin err_count++; $display("FAIL len128_data: got bad=%0d last=%h want 0 1000007f", bad, mem[DEPTH-1]); end
        cmp_count++; if (wr_count !== DEPTH || last_addr !== 32'h1FC) begin err_count++; $display("FAIL len128_writes: got n=%0d last=%h want 128 1fc", wr_count, last_addr); end
        cmp_count++; if (done !== 1'b1 || word_count !== 16'd128) begin err_count++; $display("FAIL len128_status: got done=%b wc=%0d want 1 128", done, word_count); end
    endtask

    task automatic test_error();
        clear_log();
        pulse_start();
        send_byte(8'h81, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        repeat (5) @(negedge clk);
        cmp_count++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin err_count++; $display("FAIL err_status: got error=%b done=%b busy=%b want 1 0 0", error, done, busy); end
        cmp_count++; if (bus.byte_ready !== 1'b0 || wr_count !== 0) begin err_count++; $display("FAIL err_quiet: got ready=%b writes=%0d want 0 0", bus.byte_ready, wr_count); end
        pulse_start();
        cmp_count++; if (error !== 1'b0 || busy !== 1'b1) begin err_count++; $display("FAIL err_clear: got error=%b busy=%b want 0 1", error, busy); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        cmp_count++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || bus.byte_ready !== 1'b0) begin err_count++; $display("FAIL abort_idle: got busy=%b done=%b error=%b ready=%b want 0 0 0 0", busy, done, error, bus.byte_ready); end
    endtask

    task automatic test_gaps();
        logic [7:0] bytes [10];
        int         gaps [10];
        int         bad;
        bytes = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h9A};
        gaps  = '{0, 2, 1, 3, 0, 2, 1, 0, 3, 2};
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(bytes[i], gaps[i], 1'b1);
        repeat (5) @(negedge clk);
        pulse_start();
        cmp_count++; if (busy !== 1'b1) begin err_count++; $display("FAIL gaps_start_in_pad: got busy=%b want 1", busy); end
        wait_done();
        bad = count_bad_pad(2);
        cmp_count++; if (mem[0] !== 32'h12345678 || mem[1] !== 32'h9ABCDEF0 || bad !== 0) begin err_count++; $display("FAIL gaps_data: got %h %h bad=%0d want 12345678 9abcdef0 0", mem[0], mem[1], bad); end
        cmp_count++; if (wr_count !== DEPTH || done !== 1'b1 || word_count !== 16'd2) begin err_count++; $display("FAIL gaps_status: got n=%0d done=%b wc=%0d want 128 1 2", wr_count, done, word_count); end
    endtask

    task automatic test_rst_midload();
        int bad;
        clear_log();
        pulse_start();
        send_byte(8'h02, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0); send_byte(8'hBB, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        cmp_count++; if (busy !== 1'b0 || bus.byte_ready !== 1'b0 || bus.mem_we !== 1'b0 || done !== 1'b0) begin err_count++; $display("FAIL rst_async: got busy=%b ready=%b we=%b done=%b want 0 0 0 0", busy, bus.byte_ready, bus.mem_we, done); end
        @(negedge clk); rst = 1'b0;
        clear_log();
        pulse_start();
        send_byte(8'h01, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        send_word(32'h0000_0063);
        wait_done();
        bad = count_bad_pad(0);
        cmp_count++; if (first_wdata !== 32'h0000_0063 || mem[0] !== 32'h0000_0063 || bad !== 0) begin err_count++; $display("FAIL rst_reload_data: got first=%h mem0=%h bad=%0d want 63 63 0", first_wdata, mem[0], bad); end
        cmp_count++; if (wr_count !== DEPTH || done !== 1'b1 || word_count !== 16'd1) begin err_count++; $display("FAIL rst_reload_status: got n=%0d done=%b wc=%0d want 128 1 1", wr_count, done, word_count); end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_len2();
        test_len0();
        test_len128();
        test_error();
        test_gaps();
        test_rst_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule
